// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU normalise/round datapath.
//   rmode_e    : IEEE-754 rounding modes as carried on in_rmode
//   FLG_*      : bit positions inside the 4-bit exception flag vector
//   round_inc  : decides whether the rounded fraction gets +1 ulp
package fpu_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,  // round to nearest, ties to even
    RM_RTZ = 2'd1,  // round toward zero
    RM_RUP = 2'd2,  // round toward +inf
    RM_RDN = 2'd3   // round toward -inf
  } rmode_e;

  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_NX   = 1;
  localparam int FLG_ZERO = 0;

  // lsb is the fraction LSB that survives rounding; g/r/s are the
  // guard, round and sticky bits below it.
  function automatic logic round_inc(input rmode_e rm, input logic sign,
                                     input logic lsb, input logic g,
                                     input logic r, input logic s);
    logic inc;
    inc = 1'b0;
    case (rm)
      RM_RNE: inc = g & (r | s | lsb);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = !sign & (g | r | s);
      RM_RDN: inc = sign & (g | r | s);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational leading-zero counter.
//   din  [W-1:0]          : value to scan, MSB first
//   cnt  [clog2(W+1)-1:0] : number of zeros above the first set bit (W if none)
//   zero                  : din is all zeros
module fpu_lzc #(
  parameter int W = 26
) (
  input  logic [W-1:0]           din,
  output logic [$clog2(W+1)-1:0] cnt,
  output logic                   zero
);

  localparam int CNT_W = $clog2(W+1);

  // Scanning upward lets the highest set bit win; this unrolls into a
  // priority encoder, not a sequential search.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CNT_W'(W - 1 - i);
    end
  end

  assign zero = ~|din;

endmodule

// File: rtl/fpu_norm_round_pipe.sv
// fpu_norm_round_pipe: 3-stage normalise, round and pack stage.
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid / in_ready    : input handshake
//   in_sign, in_exp        : sign and biased exponent of the hidden-bit position
//   in_mant                : {carry, hidden, fraction, G, R}
//   in_sticky              : OR of all bits below R
//   in_rmode               : rounding mode for this beat (fpu_pkg::rmode_e)
//   out_valid / out_ready  : output handshake
//   out_result             : packed {sign, exp, frac}
//   out_flags              : {overflow, underflow, inexact, zero}
// Stages: S1 carry detect + LZC, S2 shift + exponent adjust, S3 round + pack
// into the out_* registers.
module fpu_norm_round_pipe
  import fpu_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [MANT_W+3:0]       in_mant,
  input  logic                    in_sticky,
  input  logic [1:0]              in_rmode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   out_result,
  output logic [3:0]              out_flags
);

  localparam int NORM_W = MANT_W + 3;            // {hidden, fraction, G, R}
  localparam int CNT_W  = $clog2(NORM_W + 1);
  localparam int SH_W   = $clog2(NORM_W);
  localparam int XW     = EXP_W + 1;             // exponent math never wraps
  localparam logic [XW-1:0]    EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_W'((1 << EXP_W) - 2);

  // Handshake: each stage may load when it is empty or its successor moves.
  logic s1_valid, s2_valid;
  logic ready1, ready2, ready3;
  assign ready3   = !out_valid || out_ready;
  assign ready2   = !s2_valid || ready3;
  assign ready1   = !s1_valid || ready2;
  assign in_ready = ready1;

  // ---------------- S1: carry detect, LZC, stage rounding mode ----------------
  logic [CNT_W-1:0] lzc_cnt;
  logic             lzc_zero;

  fpu_lzc #(.W(NORM_W)) u_lzc (
    .din  (in_mant[NORM_W-1:0]),
    .cnt  (lzc_cnt),
    .zero (lzc_zero)
  );

  logic             s1_sign, s1_sticky, s1_zero;
  logic [EXP_W-1:0] s1_exp;
  logic [NORM_W:0]  s1_mant;
  logic [CNT_W-1:0] s1_lzc;
  rmode_e           s1_rmode;

  // ---------------- S2: shift and exponent adjust ----------------
  logic [XW-1:0]     e_base, e_lim, lzc_x, sh_x, s2_exp_d;
  logic [SH_W-1:0]   shamt;
  logic [NORM_W-1:0] s2_norm_d;
  logic              s2_sticky_d;

  always_comb begin
    // Subnormal inputs (exp 0) sit at the same scale as exp 1.
    e_base = (s1_exp == '0) ? XW'(1) : {1'b0, s1_exp};
    e_lim  = e_base - XW'(1);
    lzc_x  = XW'(s1_lzc);
    // Never shift past exponent 1: the rest of the shift becomes a subnormal.
    sh_x   = (lzc_x < e_lim) ? lzc_x : e_lim;
    // An all-zero mantissa has nothing to align; keeps shamt in range.
    shamt  = s1_zero ? '0 : SH_W'(sh_x);
    if (s1_mant[NORM_W]) begin
      s2_norm_d   = s1_mant[NORM_W:1];
      s2_exp_d    = {1'b0, s1_exp} + XW'(1);
      s2_sticky_d = s1_sticky | s1_mant[0];
    end else begin
      s2_norm_d   = s1_mant[NORM_W-1:0] << shamt;
      s2_exp_d    = e_base - XW'(shamt);
      s2_sticky_d = s1_sticky;
    end
  end

  logic              s2_sign, s2_sticky;
  logic [XW-1:0]     s2_exp;
  logic [NORM_W-1:0] s2_norm;
  rmode_e            s2_rmode;

  // ---------------- S3: round and pack ----------------
  logic               hidden, g, r, lsb, nx, tiny, inc, inc_near, ovf, to_inf;
  logic [MANT_W-1:0]  frac;
  logic [MANT_W+1:0]  sig;
  logic [XW-1:0]      exp_rnd, exp_near;
  logic [EXP_W-1:0]   exp_field;
  logic [EXP_W+MANT_W:0] res_d;
  logic [3:0]         flg_d;

  always_comb begin
    hidden = s2_norm[NORM_W-1];
    frac   = s2_norm[NORM_W-2:2];
    lsb    = s2_norm[2];
    g      = s2_norm[1];
    r      = s2_norm[0];
    nx     = g | r | s2_sticky;
    tiny   = !hidden;
    inc      = round_inc(s2_rmode, s2_sign, lsb, g, r, s2_sticky);
    inc_near = round_inc(RM_RNE, s2_sign, lsb, g, r, s2_sticky);
    sig      = {1'b0, hidden, frac} + (MANT_W+2)'(inc);
    exp_rnd  = s2_exp + XW'(sig[MANT_W+1]);
    // Overflow is decided on magnitude (nearest rounding); the mode only
    // chooses between Inf and the largest finite value.
    exp_near = s2_exp + XW'(inc_near & hidden & (&frac));
    ovf      = (exp_rnd >= EXP_MAX) || (exp_near >= EXP_MAX);
    to_inf   = (s2_rmode == RM_RNE) || (s2_rmode == RM_RUP && !s2_sign) ||
               (s2_rmode == RM_RDN && s2_sign);

    // A subnormal that rounds into the hidden bit keeps s2_exp, which is 1.
    if (sig[MANT_W+1])   exp_field = exp_rnd[EXP_W-1:0];
    else if (sig[MANT_W]) exp_field = s2_exp[EXP_W-1:0];
    else                 exp_field = '0;

    res_d = {s2_sign, exp_field, sig[MANT_W-1:0]};
    flg_d = '0;
    if (ovf) begin
      flg_d[FLG_OVF] = 1'b1;
      flg_d[FLG_NX]  = 1'b1;
      res_d = to_inf ? {s2_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                     : {s2_sign, EXP_MAXF, {MANT_W{1'b1}}};
    end else begin
      flg_d[FLG_UNF]  = tiny & nx;
      flg_d[FLG_NX]   = nx;
      flg_d[FLG_ZERO] = (exp_field == '0) && (sig[MANT_W-1:0] == '0);
    end
  end

  // Control and output registers: cleared by reset so no beat survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      if (ready1) s1_valid <= in_valid;
      if (ready2) s2_valid <= s1_valid;
      if (ready3) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_result <= res_d;
          out_flags  <= flg_d;
        end
      end
    end
  end

  // NOTE: payload registers are not reset; their valid bit already masks stale contents.
  always_ff @(posedge clk) begin
    if (in_valid && ready1) begin
      s1_sign   <= in_sign;
      s1_exp    <= in_exp;
      s1_mant   <= in_mant;
      s1_sticky <= in_sticky;
      s1_rmode  <= rmode_e'(in_rmode);
      s1_lzc    <= lzc_cnt;
      s1_zero   <= lzc_zero;
    end
    if (s1_valid && ready2) begin
      s2_sign   <= s1_sign;
      s2_rmode  <= s1_rmode;
      s2_exp    <= s2_exp_d;
      s2_norm   <= s2_norm_d;
      s2_sticky <= s2_sticky_d;
    end
  end

endmodule

// File: tb/tb_fpu_norm_round_pipe.sv
// tb_fpu_norm_round_pipe: directed vectors with hand-computed results,
// checked by a scoreboard queue and an independent output monitor.
module tb_fpu_norm_round_pipe;
  import fpu_pkg::*;

  logic        clk, rst;
  logic        in_valid, in_ready, in_sign, in_sticky;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic [1:0]  in_rmode;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  fpu_norm_round_pipe #(.MANT_W(23), .EXP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_sticky  (in_sticky),
    .in_rmode   (in_rmode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] mant;
    logic        sticky;
    logic [1:0]  rm;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  vec_t  vecs[17];
  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic vec_t mk(input string name, input logic sign, input logic [7:0] exp,
                              input logic [26:0] mant, input logic sticky, input logic [1:0] rm,
                              input logic [31:0] res, input logic [3:0] flg);
    vec_t v;
    v.name = name; v.sign = sign; v.exp = exp; v.mant = mant;
    v.sticky = sticky; v.rm = rm; v.res = res; v.flg = flg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Called just after a posedge; returns just after the posedge that took the beat.
  task automatic send(input vec_t v);
    int waited;
    waited    = 0;
    in_valid  = 1'b1;
    in_sign   = v.sign;
    in_exp    = v.exp;
    in_mant   = v.mant;
    in_sticky = v.sticky;
    in_rmode  = v.rm;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check({v.name, "_accept_timeout"}, 32'(in_ready), 32'(1));
    else exp_q.push_back('{name: v.name, res: v.res, flg: v.flg});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'(0));
  endtask

  // Monitor: pops on every accepted output beat and checks stall stability.
  logic        held;
  logic [31:0] held_res;
  logic [3:0]  held_flg;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        check("stall_result", out_result, held_res);
        check("stall_flags", 32'(out_flags), 32'(held_flg));
      end
      if (out_valid && out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_result"}, out_result, e.res);
          check({e.name, "_flags"}, 32'(out_flags), 32'(e.flg));
        end
      end else if (out_valid) begin
        held     = 1'b1;
        held_res = out_result;
        held_flg = out_flags;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int lat;
    //                name          s   exp    mant          S  rm  result        flags
    vecs[0]  = mk("carry",        0, 8'h7F, 27'h4000000, 0, 0, 32'h40000000, 4'h0);
    vecs[1]  = mk("left_norm",    0, 8'h7F, 27'h0123454, 0, 0, 32'h3D11A2A0, 4'h0);
    vecs[2]  = mk("rne_tie_even", 0, 8'h7F, 27'h2000002, 0, 0, 32'h3F800000, 4'h2);
    vecs[3]  = mk("rne_tie_odd",  0, 8'h7F, 27'h2000006, 0, 0, 32'h3F800002, 4'h2);
    vecs[4]  = mk("ovf_rne",      0, 8'hFE, 27'h3FFFFFE, 0, 0, 32'h7F800000, 4'hA);
    vecs[5]  = mk("ovf_rtz",      0, 8'hFE, 27'h3FFFFFE, 0, 1, 32'h7F7FFFFF, 4'hA);
    vecs[6]  = mk("subnormal",    0, 8'h03, 27'h0080002, 1, 0, 32'h00080002, 4'h6);
    vecs[7]  = mk("zero_pos",     0, 8'h10, 27'h0000000, 0, 0, 32'h00000000, 4'h1);
    vecs[8]  = mk("zero_neg",     1, 8'h10, 27'h0000000, 0, 1, 32'h80000000, 4'h1);
    vecs[9]  = mk("subn_to_norm", 0, 8'h01, 27'h1FFFFFF, 0, 0, 32'h00800000, 4'h6);
    vecs[10] = mk("rdn_neg",      1, 8'h7F, 27'h2000000, 1, 3, 32'hBF800001, 4'h2);
    vecs[11] = mk("rup_neg",      1, 8'h7F, 27'h2000000, 1, 2, 32'hBF800000, 4'h2);
    vecs[12] = mk("carry_sticky", 0, 8'h80, 27'h4000001, 0, 0, 32'h40800000, 4'h2);
    vecs[13] = mk("ovf_carry",    0, 8'hFF, 27'h4000000, 0, 1, 32'h7F7FFFFF, 4'hA);
    vecs[14] = mk("ovf_rdn_pos",  0, 8'hFE, 27'h3FFFFFE, 0, 3, 32'h7F7FFFFF, 4'hA);
    vecs[15] = mk("ovf_rup_pos",  0, 8'hFE, 27'h3FFFFFC, 1, 2, 32'h7F800000, 4'hA);
    vecs[16] = mk("rne_up",       0, 8'h7F, 27'h2000003, 0, 0, 32'h3F800001, 4'h2);

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_sticky = 1'b0; in_rmode = '0; out_ready = 1'b1; held = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_out_result", out_result, 32'h0);
    check("reset_out_flags", 32'(out_flags), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));

    // Latency of a lone beat.
    @(posedge clk); #1;
    send(vecs[0]);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(3));
    drain("drain_latency");

    // All vectors back to back, no backpressure.
    @(posedge clk); #1;
    foreach (vecs[i]) send(vecs[i]);
    in_valid = 1'b0;
    drain("drain_stream");

    // Backpressure: 5 beats, out_ready low for 6 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(vecs[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'(0));
        check("bp_held_beats", 32'(exp_q.size()), 32'(3));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset mid-stream with a full pipe.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(vecs[5]); send(vecs[6]); send(vecs[7]);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("no_stale_beat", 32'(out_valid), 32'(0));

    // Pipe still works after the reset.
    @(posedge clk); #1;
    send(vecs[16]);
    in_valid = 1'b0;
    drain("drain_after_reset");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
